myuart_apb_master: RTL and testbench

MYUART_APB_MASTER -- requirements
Module: myuart_apb_master

---
 rtl/myuart_apb_master.sv | 186 ++++++++++++++++++
 tb/tb_myuart_apb_master.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myuart_apb_master.sv
// ============================================================================
// Module      : myuart_apb_master
// Description : Command-FIFO driven APB master; holds off writes to 0x08 while
//               the responder reports TX busy. Optional ACCESS timeout is
//               enabled by defining MYUART_APB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module myuart_apb_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [5:0]  paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        interrupt
);

    localparam int             c_AW         = $clog2(FIFO_DEPTH);
    localparam logic [5:0]     c_BLOCK_ADDR = 6'h08;
    localparam logic [c_AW-1:0] c_PTR_ONE   = 1;
    localparam logic [c_AW:0]  c_CNT_ONE    = 1;
    localparam logic [c_AW:0]  c_CNT_FULL   = (c_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Entry layout: {write, addr[5:0], wdata[31:0]}
    logic [38:0]     r_fifo [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [38:0] w_head;
    logic        w_head_avail;
    logic        w_head_blocked;
    logic        w_can_issue;
    logic        w_done;
    logic        w_tmo_hit;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CNT_FULL);
    assign cmd_ready = !w_full && !preset;
    assign w_push    = cmd_valid && cmd_ready;

    // An empty FIFO falls through so a fresh command can start on the next cycle.
    assign w_head         = w_empty ? {cmd_write, cmd_addr, cmd_wdata} : r_fifo[r_rptr];
    assign w_head_avail   = !w_empty || w_push;
    assign w_head_blocked = w_head[38] && (w_head[37:32] == c_BLOCK_ADDR) && interrupt;
    assign w_can_issue    = w_head_avail && !w_head_blocked;

    assign w_done  = (r_state == S_ACCESS) && (pready || w_tmo_hit);
    assign psel    = (r_state != S_IDLE);
    assign penable = (r_state == S_ACCESS);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_issue) begin
                    w_state_nxt = S_SETUP;
                    w_pop       = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (w_done) begin
                    if (w_can_issue) begin
                        w_state_nxt = S_SETUP;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= S_IDLE;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            if (w_pop) begin
                pwrite <= w_head[38];
                paddr  <= w_head[37:32];
                pwdata <= w_head[31:0];
            end
            rsp_valid <= w_done;
            rsp_rdata <= (w_done && !pwrite && pready) ? prdata : '0;
        end
    end

`ifdef MYUART_APB_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_ONE = 1;
    localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT - 1);

    logic [c_TW-1:0] r_tmo_cnt;

    // Fires on the last permitted ACCESS cycle when the responder is still stalling.
    assign w_tmo_hit = (r_state == S_ACCESS) && (r_tmo_cnt == c_TMO_MAX) && !pready;

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_tmo_cnt <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (r_state == S_SETUP) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !w_done) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end
            rsp_err <= w_done && w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_myuart_apb_master.sv
// ============================================================================
// Module      : tb_myuart_apb_master
// Description : Table-driven and randomized self-checking bench for
//               myuart_apb_master with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_myuart_apb_master;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 16;
`ifdef MYUART_APB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        interrupt;

    myuart_apb_master #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .interrupt(interrupt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic smp();
        @(negedge pclk);
    endtask

    function automatic logic [31:0] rd_val(logic [5:0] a);
        return 32'hC3A5_0000 | 32'(a);
    endfunction

    typedef struct {
        logic        write;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prd;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [6];

    // Single transfer from IDLE: checks SETUP/ACCESS timing, stability and response.
    task automatic run_vec(input vec_t v, input int idx);
        tick();
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; pready = 1'b0;
        smp();
        chk($sformatf("v%0d cmd_ready", idx), cmd_ready, 1);
        chk($sformatf("v%0d idle psel", idx), psel, 0);
        tick();
        cmd_valid = 1'b0;
        smp();
        chk($sformatf("v%0d setup psel", idx), psel, 1);
        chk($sformatf("v%0d setup penable", idx), penable, 0);
        chk($sformatf("v%0d setup paddr", idx), paddr, v.addr);
        chk($sformatf("v%0d setup pwrite", idx), pwrite, v.write);
        chk($sformatf("v%0d setup pwdata", idx), pwdata, v.wdata);
        for (int i = 0; i <= v.waits; i++) begin
            tick();
            pready = (i == v.waits);
            prdata = (i == v.waits) ? v.prd : 32'h0BAD_0000 + 32'(i);
            smp();
            chk($sformatf("v%0d access psel/penable", idx), {psel, penable}, 2'b11);
            chk($sformatf("v%0d access paddr", idx), paddr, v.addr);
            chk($sformatf("v%0d access pwdata", idx), pwdata, v.wdata);
            chk($sformatf("v%0d early rsp", idx), rsp_valid, 0);
        end
        tick();
        pready = 1'b0; prdata = '0;
        smp();
        chk($sformatf("v%0d rsp_valid", idx), rsp_valid, 1);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rsp_err", idx), rsp_err, 0);
        chk($sformatf("v%0d back to idle", idx), psel, 0);
        tick();
        smp();
        chk($sformatf("v%0d rsp single pulse", idx), rsp_valid, 0);
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct packed {
        logic        write;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        exp_cmd [$];
    bit          rsp_due;
    logic [32:0] rsp_exp;
    bit          exp_setup_next;
    bit          chk_next;
    bit          prev_setup;
    int          acc_cnt;
    cmd_t        cur;

    task automatic monitor();
        bit   is_setup;
        bit   is_access;
        bit   done;
        cmd_t head;
        is_setup  = psel && !penable;
        is_access = psel && penable;
        if (chk_next) chk("rnd issue timing", is_setup, exp_setup_next);
        if (prev_setup) chk("rnd setup->access", is_access, 1);
        if (!psel) chk("rnd idle penable", penable, 0);
        chk("rnd rsp_valid", rsp_valid, rsp_due);
        if (rsp_due && rsp_valid) begin
            chk("rnd rsp_rdata", rsp_rdata, rsp_exp[31:0]);
            chk("rnd rsp_err", rsp_err, rsp_exp[32]);
        end
        rsp_due = 1'b0;
        if (is_setup) begin
            chk("rnd setup has queued cmd", exp_cmd.size() > 0, 1);
            if (exp_cmd.size() > 0) begin
                cur = exp_cmd.pop_front();
                chk("rnd paddr", paddr, cur.addr);
                chk("rnd pwrite", pwrite, cur.write);
                chk("rnd pwdata", pwdata, cur.wdata);
            end
            acc_cnt = 0;
        end
        done = 1'b0;
        if (is_access) begin
            acc_cnt++;
            chk("rnd stable", {pwrite, paddr, pwdata}, {cur.write, cur.addr, cur.wdata});
            done = pready || (TMO_EN && acc_cnt == TIMEOUT);
            if (done) begin
                rsp_due = 1'b1;
                rsp_exp = pready ? {1'b0, (cur.write ? 32'h0 : prdata)} : {1'b1, 32'h0};
            end
        end
        chk("rnd cmd_ready", cmd_ready, exp_cmd.size() < FIFO_DEPTH);
        if (cmd_valid && cmd_ready) exp_cmd.push_back({cmd_write, cmd_addr, cmd_wdata});
        exp_setup_next = 1'b0;
        if ((!psel || done) && exp_cmd.size() > 0) begin
            head = exp_cmd[0];
            exp_setup_next = !(head.write && head.addr == 6'h08 && interrupt);
        end
        prev_setup = is_setup;
        chk_next   = 1'b1;
    endtask

    initial begin
        int acc;
        int r;
        int last;
        int nset;
        int nrsp;
        int acc_cycles;
        bit seen;
        bit err_seen;
        logic [31:0] rdata_seen;

        tbl[0] = '{1'b1, 6'h04, 32'h0000_0005, 0, 32'hFFFF_FFFF, 32'h0};
        tbl[1] = '{1'b0, 6'h08, 32'h0,         3, 32'h0000_00A5, 32'h0000_00A5};
        tbl[2] = '{1'b0, 6'h3F, 32'h1111_2222, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[3] = '{1'b1, 6'h08, 32'h1234_5678, 2, 32'h0000_0055, 32'h0};
        tbl[4] = '{1'b0, 6'h00, 32'h0,         1, 32'h8000_0001, 32'h8000_0001};
        tbl[5] = '{1'b1, 6'h3F, 32'hFFFF_FFFF, 5, 32'h0000_0001, 32'h0};

        preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h15;
        cmd_wdata = 32'h7777_7777; prdata = '0; pready = 1'b0; interrupt = 1'b0;

        // Reset state
        tick(); tick();
        smp();
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst psel/penable", {psel, penable}, 2'b00);
        chk("rst pwrite", pwrite, 0);
        chk("rst paddr", paddr, 0);
        chk("rst pwdata", pwdata, 0);
        chk("rst rsp", {rsp_valid, rsp_err}, 2'b00);
        chk("rst rsp_rdata", rsp_rdata, 0);
        tick();
        cmd_valid = 1'b0; preset = 1'b0;
        smp();
        chk("post-rst idle", psel, 0);
        chk("post-rst cmd_ready", cmd_ready, 1);

        foreach (tbl[i]) run_vec(tbl[i], i);

        // FIFO full: one transfer in flight plus FIFO_DEPTH queued.
        pready = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h10 + 6'(acc); cmd_wdata = '0;
            smp();
            if (cmd_ready) acc++;
        end
        tick();
        cmd_valid = 1'b0;
        smp();
        chk("full accepted count", acc, FIFO_DEPTH + 1);
        chk("full cmd_ready", cmd_ready, 0);
        r = 0; last = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            pready = 1'b1; prdata = rd_val(paddr);
            smp();
            if (rsp_valid) begin
                chk("full order rdata", rsp_rdata, rd_val(6'h10 + 6'(r)));
                if (r > 0) chk("full b2b gap", c - last, 2);
                if (r < FIFO_DEPTH) chk("full b2b setup with rsp", psel && !penable, 1);
                last = c;
                r++;
            end
        end
        pready = 1'b0;
        chk("full completions", r, FIFO_DEPTH + 1);

        // Blocked write to 0x08 holds the queue in order.
        interrupt = 1'b1; pready = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h08; cmd_wdata = 32'hCAFE_0008;
        tick();
        cmd_write = 1'b0; cmd_addr = 6'h04; cmd_wdata = '0;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            prdata = rd_val(paddr);
            smp();
            if (psel) seen = 1'b1;
        end
        chk("blocked no psel", seen, 0);
        tick();
        interrupt = 1'b0;
        nset = 0; nrsp = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            prdata = rd_val(paddr);
            smp();
            if (psel && !penable) begin
                if (nset == 0) begin
                    chk("unblock latency", c, 0);
                    chk("unblock 1st paddr", paddr, 6'h08);
                    chk("unblock 1st pwrite", pwrite, 1);
                    chk("unblock 1st pwdata", pwdata, 32'hCAFE_0008);
                end else if (nset == 1) begin
                    chk("unblock 2nd paddr", paddr, 6'h04);
                    chk("unblock 2nd pwrite", pwrite, 0);
                end
                nset++;
            end
            if (rsp_valid) begin
                if (nrsp == 0) chk("unblock 1st rdata", rsp_rdata, 32'h0);
                else if (nrsp == 1) chk("unblock 2nd rdata", rsp_rdata, rd_val(6'h04));
                nrsp++;
            end
        end
        chk("unblock setups", nset, 2);
        chk("unblock responses", nrsp, 2);
        pready = 1'b0;

        // Stalled responder: timeout abort when enabled, otherwise ACCESS persists.
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h2A;
        tick();
        cmd_valid = 1'b0;
        acc_cycles = 0; err_seen = 1'b0; rdata_seen = '0; seen = 1'b0;
        for (int c = 0; c < 120; c++) begin
            tick();
            smp();
            if (psel && penable) acc_cycles++;
            if (rsp_valid && !seen) begin
                seen = 1'b1; err_seen = rsp_err; rdata_seen = rsp_rdata;
            end
        end
        chk("stall access cycles", acc_cycles, TMO_EN ? TIMEOUT : 120);
        chk("stall rsp seen", seen, TMO_EN);
        chk("stall rsp_err", err_seen, TMO_EN);
        chk("stall rsp_rdata", rdata_seen, 0);
        tick(); pready = 1'b1;
        tick(); pready = 1'b0;
        repeat (3) tick();

        // Reset in ACCESS with two commands queued.
        for (int i = 0; i < 3; i++) begin
            tick();
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'(i + 1);
        end
        tick();
        cmd_valid = 1'b0; preset = 1'b1;
        smp();
        chk("pre-abort access", {psel, penable}, 2'b11);
        chk("abort cmd_ready in reset", cmd_ready, 0);
        tick();
        preset = 1'b0;
        smp();
        chk("abort psel", psel, 0);
        chk("abort rsp_valid", rsp_valid, 0);
        chk("abort cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            smp();
            if (psel || rsp_valid) seen = 1'b1;
        end
        chk("abort fifo flushed", seen, 0);

        // Randomized traffic against the reference model.
        exp_cmd.delete();
        rsp_due = 1'b0; chk_next = 1'b0; prev_setup = 1'b0; acc_cnt = 0; cur = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            cmd_valid = ($urandom_range(0, 99) < 40);
            cmd_write = 1'($urandom);
            cmd_addr  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            cmd_wdata = $urandom;
            if ($urandom_range(0, 9) == 0) interrupt = ~interrupt;
            pready = ($urandom_range(0, 99) < 45);
            prdata = $urandom;
            smp();
            monitor();
        end
        for (int c = 0; c < 400; c++) begin
            if (exp_cmd.size() == 0 && !psel && !rsp_due) break;
            tick();
            cmd_valid = 1'b0; interrupt = 1'b0; pready = 1'b1; prdata = $urandom;
            smp();
            monitor();
        end
        chk("drain queue empty", exp_cmd.size(), 0);
        chk("drain idle", psel, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
